// File: rtl/rf_write_funnel_pkg.sv
// Shared definitions for the register-file write funnel: register address
// width, data width, port counts and the writeback request payload.
package rf_write_funnel_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned REG_AW = 6;
  localparam int unsigned N_RD   = 3;
  localparam int unsigned N_WB   = 2;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_funnel.sv
// Write-side front end for the 64-deep 3R/1W register RAM.
// Accepts up to two writeback requests per cycle into an in-order queue,
// drains one entry per cycle into the RAM write port, and forwards queued
// data onto the three read ports so readers never see a stale value.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wb_valid_i/ready  per-port writeback handshake (port 0 is older)
//   wb_addr_i/data_i  packed per-port request payload, port p at slice p
//   ram_*_o           RAM write port, driven from the queue head
//   rd_addr_i         read addresses (also drive RAM addr0..2 externally)
//   ram_dout_i        RAM combinational read data, port r at slice r
//   rd_data_o/fwd_o   read data after forwarding, and forward indication
module rf_write_funnel
  import rf_write_funnel_pkg::REG_AW;
  import rf_write_funnel_pkg::N_RD;
  import rf_write_funnel_pkg::N_WB;
#(
  parameter int unsigned WIDTH  = rf_write_funnel_pkg::WIDTH,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_WB-1:0]          wb_valid_i,
  input  logic [N_WB*REG_AW-1:0]   wb_addr_i,
  input  logic [N_WB*WIDTH-1:0]    wb_data_i,
  output logic [N_WB-1:0]          wb_ready_o,
  output logic [REG_AW-1:0]        ram_addrw_o,
  output logic [WIDTH-1:0]         ram_din_o,
  output logic                     ram_wea_o,
  input  logic [N_RD*REG_AW-1:0]   rd_addr_i,
  input  logic [N_RD*WIDTH-1:0]    ram_dout_i,
  output logic [N_RD*WIDTH-1:0]    rd_data_o,
  output logic [N_RD-1:0]          rd_fwd_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [REG_AW-1:0] q_addr [QDEPTH];
  logic [WIDTH-1:0]  q_data [QDEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [N_WB-1:0]   fire;
  logic              pop;
  logic [PTR_W-1:0]  slot1;

  // Ready depends only on registered occupancy; no credit for a same-cycle pop.
  assign wb_ready_o[0] = (count <= CNT_W'(QDEPTH - 1));
  assign wb_ready_o[1] = (count <= CNT_W'(QDEPTH - 2));

  assign fire  = wb_valid_i & wb_ready_o;
  assign pop   = (count != '0);
  // Port 1 lands behind port 0, or in the tail slot when port 0 is idle.
  assign slot1 = tail + PTR_W'(fire[0]);

  // Drain: head entry goes to the RAM whenever the queue is non-empty.
  assign ram_wea_o   = pop;
  assign ram_addrw_o = q_addr[head];
  assign ram_din_o   = q_data[head];

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(fire[0]) + PTR_W'(fire[1]);
      count <= count + CNT_W'(fire[0]) + CNT_W'(fire[1]) - CNT_W'(pop);
    end
  end

  // Queue payload storage; contents are don't-care outside [head, head+count).
  always_ff @(posedge clk) begin
    if (fire[0]) begin
      q_addr[tail] <= wb_addr_i[0 +: REG_AW];
      q_data[tail] <= wb_data_i[0 +: WIDTH];
    end
    if (fire[1]) begin
      q_addr[slot1] <= wb_addr_i[REG_AW +: REG_AW];
      q_data[slot1] <= wb_data_i[WIDTH +: WIDTH];
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    rd_data_o = ram_dout_i;
    rd_fwd_o  = '0;
    for (int r = 0; r < N_RD; r++) begin
      for (int i = 0; i < QDEPTH; i++) begin
        idx = head + PTR_W'(i);
        if ((CNT_W'(i) < count) && (q_addr[idx] == rd_addr_i[r*REG_AW +: REG_AW])) begin
          rd_data_o[r*WIDTH +: WIDTH] = q_data[idx];
          rd_fwd_o[r]                 = 1'b1;
        end
      end
    end
  end

endmodule
